// File: rtl/sparc_ifu_wselq_dp.sv
// Icache way-select datapath: AND-OR fetch select with optional output register,
// registered-index ASI/BIST diagnostic read, and a way-select mutual-exclusion monitor.
module sparc_ifu_wselq_dp #(
    parameter int NWAYS = 4,
    parameter int DW    = 34,
    parameter int PIPE  = 1,
    parameter int ECNTW = 8,
    localparam int WAYW = $clog2(NWAYS)
) (
    input  logic                  rclk,
    input  logic                  reset,
    input  logic                  se,
    input  logic                  fet_vld_s1,
    input  logic [NWAYS*DW-1:0]   icd_fetdata_s1,
    input  logic [NWAYS*DW-1:0]   icd_topdata_s1,
    input  logic [NWAYS-1:0]      itlb_waysel_s1,
    input  logic                  asi_rd_req_f,
    input  logic [WAYW-1:0]       asi_way_f,
    input  logic                  err_clr,
    output logic [DW-1:0]         fdp_fetdata,
    output logic [DW-1:0]         fdp_topdata,
    output logic                  fdp_vld,
    output logic                  fdp_hit,
    output logic                  asi_rd_vld,
    output logic [2*DW-1:0]       asi_data,
    output logic                  waysel_err,
    output logic [ECNTW-1:0]      waysel_err_cnt
);

    logic unused_se;
    assign unused_se = se;

    logic [DW-1:0] fet_way [NWAYS];
    logic [DW-1:0] top_way [NWAYS];
    logic [DW-1:0] fet_or  [NWAYS+1];
    logic [DW-1:0] top_or  [NWAYS+1];

    // AND-OR select: multi-hot selects merge the chosen ways, zero-hot yields zero.
    assign fet_or[0] = '0;
    assign top_or[0] = '0;
    generate
        for (genvar gi = 0; gi < NWAYS; gi++) begin : g_way
            assign fet_way[gi]  = icd_fetdata_s1[gi*DW +: DW];
            assign top_way[gi]  = icd_topdata_s1[gi*DW +: DW];
            assign fet_or[gi+1] = fet_or[gi] | (fet_way[gi] & {DW{itlb_waysel_s1[gi]}});
            assign top_or[gi+1] = top_or[gi] | (top_way[gi] & {DW{itlb_waysel_s1[gi]}});
        end
    endgenerate

    logic sel_hit;
    assign sel_hit = fet_vld_s1 & (|itlb_waysel_s1);

    generate
        if (PIPE != 0) begin : g_pipe
            logic [DW-1:0] fet_reg;
            logic [DW-1:0] top_reg;
            logic          vld_reg;
            logic          hit_reg;

            always_ff @(posedge rclk or posedge reset) begin
                if (reset) begin
                    fet_reg <= '0;
                    top_reg <= '0;
                    vld_reg <= 1'b0;
                    hit_reg <= 1'b0;
                end else begin
                    fet_reg <= fet_or[NWAYS];
                    top_reg <= top_or[NWAYS];
                    vld_reg <= fet_vld_s1;
                    hit_reg <= sel_hit;
                end
            end

            assign fdp_fetdata = fet_reg;
            assign fdp_topdata = top_reg;
            assign fdp_vld     = vld_reg;
            assign fdp_hit     = hit_reg;
        end else begin : g_comb
            // Forced low during reset so the outputs read zero while reset is held.
            assign fdp_fetdata = reset ? '0 : fet_or[NWAYS];
            assign fdp_topdata = reset ? '0 : top_or[NWAYS];
            assign fdp_vld     = ~reset & fet_vld_s1;
            assign fdp_hit     = ~reset & sel_hit;
        end
    endgenerate

    // ASI read: index is flopped, then muxes the array data of the following cycle.
    logic            asi_vld_reg;
    logic [WAYW-1:0] asi_way_reg;

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            asi_vld_reg <= 1'b0;
            asi_way_reg <= '0;
        end else begin
            asi_vld_reg <= asi_rd_req_f;
            asi_way_reg <= asi_way_f;
        end
    end

    logic [DW-1:0] asi_fet;
    logic [DW-1:0] asi_top;
    assign asi_fet    = fet_way[asi_way_reg];
    assign asi_top    = top_way[asi_way_reg];
    assign asi_rd_vld = asi_vld_reg;
    assign asi_data   = reset ? '0 :
                        {asi_top[DW-1:DW-2], asi_fet[DW-1:DW-2], asi_top[DW-3:0], asi_fet[DW-3:0]};

    // Multi-hot detect: clearing the lowest set bit leaves something only if >1 bit set.
    logic multi_hot;
    logic err_event;
    assign multi_hot = (itlb_waysel_s1 & (itlb_waysel_s1 - NWAYS'(1))) != '0;
    assign err_event = fet_vld_s1 & multi_hot;

    logic             err_reg;
    logic [ECNTW-1:0] cnt_reg;

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (err_event) begin
            err_reg <= 1'b1;
            if (err_clr)
                cnt_reg <= ECNTW'(1);
            else if (cnt_reg != {ECNTW{1'b1}})
                cnt_reg <= cnt_reg + ECNTW'(1);
        end else if (err_clr) begin
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end
    end

    assign waysel_err     = err_reg;
    assign waysel_err_cnt = cnt_reg;

endmodule

// File: tb/tb_sparc_ifu_wselq_dp.sv
// Directed bench: registered 4-way/34-bit instance and combinational 8-way/18-bit instance.
module tb_sparc_ifu_wselq_dp;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NWAYS=4, DW=34, PIPE=1
    logic         a_vld, a_req, a_clr;
    logic [135:0] a_fet, a_top;
    logic [3:0]   a_ws;
    logic [1:0]   a_way;
    logic [33:0]  a_fdp_fet, a_fdp_top;
    logic         a_fdp_vld, a_fdp_hit, a_asi_vld, a_err;
    logic [67:0]  a_asi_data;
    logic [7:0]   a_cnt;

    // Instance B: NWAYS=8, DW=18, PIPE=0
    logic         b_vld, b_req, b_clr;
    logic [143:0] b_fet, b_top;
    logic [7:0]   b_ws;
    logic [2:0]   b_way;
    logic [17:0]  b_fdp_fet, b_fdp_top;
    logic         b_fdp_vld, b_fdp_hit, b_asi_vld, b_err;
    logic [35:0]  b_asi_data;
    logic [7:0]   b_cnt;

    sparc_ifu_wselq_dp #(.NWAYS(4), .DW(34), .PIPE(1), .ECNTW(8)) u_dut_a (
        .rclk(clk), .reset(reset), .se(1'b0),
        .fet_vld_s1(a_vld), .icd_fetdata_s1(a_fet), .icd_topdata_s1(a_top),
        .itlb_waysel_s1(a_ws), .asi_rd_req_f(a_req), .asi_way_f(a_way), .err_clr(a_clr),
        .fdp_fetdata(a_fdp_fet), .fdp_topdata(a_fdp_top), .fdp_vld(a_fdp_vld),
        .fdp_hit(a_fdp_hit), .asi_rd_vld(a_asi_vld), .asi_data(a_asi_data),
        .waysel_err(a_err), .waysel_err_cnt(a_cnt)
    );

    sparc_ifu_wselq_dp #(.NWAYS(8), .DW(18), .PIPE(0), .ECNTW(8)) u_dut_b (
        .rclk(clk), .reset(reset), .se(1'b0),
        .fet_vld_s1(b_vld), .icd_fetdata_s1(b_fet), .icd_topdata_s1(b_top),
        .itlb_waysel_s1(b_ws), .asi_rd_req_f(b_req), .asi_way_f(b_way), .err_clr(b_clr),
        .fdp_fetdata(b_fdp_fet), .fdp_topdata(b_fdp_top), .fdp_vld(b_fdp_vld),
        .fdp_hit(b_fdp_hit), .asi_rd_vld(b_asi_vld), .asi_data(b_asi_data),
        .waysel_err(b_err), .waysel_err_cnt(b_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [67:0] exp_asi [4];

    initial begin
        a_vld = 0; a_req = 0; a_clr = 0; a_fet = '0; a_top = '0; a_ws = '0; a_way = '0;
        b_vld = 0; b_req = 0; b_clr = 0; b_fet = '0; b_top = '0; b_ws = '0; b_way = '0;
        #1 reset = 1'b1;

        // Reset held 3 cycles with random stimulus on A
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 136; k++) begin
                a_fet[k] = 1'($urandom);
                a_top[k] = 1'($urandom);
            end
            a_ws  = 4'($urandom);
            a_vld = 1'($urandom);
            a_req = 1'($urandom);
            a_way = 2'($urandom);
            a_clr = 1'($urandom);
            tick();
        end
        check("rst_fet",     128'(a_fdp_fet),  128'(0));
        check("rst_top",     128'(a_fdp_top),  128'(0));
        check("rst_vld",     128'(a_fdp_vld),  128'(0));
        check("rst_hit",     128'(a_fdp_hit),  128'(0));
        check("rst_asi_vld", 128'(a_asi_vld),  128'(0));
        check("rst_asi_dat", 128'(a_asi_data), 128'(0));
        check("rst_err",     128'(a_err),      128'(0));
        check("rst_cnt",     128'(a_cnt),      128'(0));

        // Single-way hit on way 2
        reset = 1'b0;
        a_req = 0; a_clr = 0; a_way = '0;
        a_vld = 1; a_ws = 4'b0100;
        a_fet[68 +: 34] = 34'h2_DEAD_BEEF;
        a_top[68 +: 34] = 34'h1_2345_6789;
        tick();
        check("hit_fet", 128'(a_fdp_fet), 128'(34'h2_DEAD_BEEF));
        check("hit_top", 128'(a_fdp_top), 128'(34'h1_2345_6789));
        check("hit_vld", 128'(a_fdp_vld), 128'(1));
        check("hit_hit", 128'(a_fdp_hit), 128'(1));
        check("hit_err", 128'(a_err),     128'(0));

        // Miss: zero-hot with valid
        a_ws = 4'b0000;
        tick();
        check("miss_fet", 128'(a_fdp_fet), 128'(0));
        check("miss_vld", 128'(a_fdp_vld), 128'(1));
        check("miss_hit", 128'(a_fdp_hit), 128'(0));
        check("miss_err", 128'(a_err),     128'(0));

        // Multi-hot without valid is not an error
        a_vld = 0; a_ws = 4'b1111;
        tick();
        check("novld_vld", 128'(a_fdp_vld), 128'(0));
        check("novld_hit", 128'(a_fdp_hit), 128'(0));
        check("novld_err", 128'(a_err),     128'(0));

        // Multi-hot event: ways 0 and 1 ORed
        a_fet[0  +: 34] = 34'h1;
        a_fet[34 +: 34] = 34'h2;
        a_vld = 1; a_ws = 4'b0011;
        tick();
        check("mh_fet", 128'(a_fdp_fet), 128'(34'h3));
        check("mh_hit", 128'(a_fdp_hit), 128'(1));
        check("mh_err", 128'(a_err),     128'(1));
        check("mh_cnt", 128'(a_cnt),     128'(1));

        // Sticky across an idle cycle
        a_vld = 0;
        tick();
        check("sticky_err", 128'(a_err), 128'(1));
        check("sticky_cnt", 128'(a_cnt), 128'(1));

        // Counter to 254, 255, then saturated after 300 events
        a_vld = 1;
        for (int i = 0; i < 253; i++) tick();
        check("cnt_254", 128'(a_cnt), 128'(254));
        tick();
        check("cnt_255", 128'(a_cnt), 128'(255));
        for (int i = 0; i < 45; i++) tick();
        check("cnt_sat", 128'(a_cnt), 128'(255));

        // err_clr colliding with an event: event wins
        a_clr = 1;
        tick();
        check("clr_ev_err", 128'(a_err), 128'(1));
        check("clr_ev_cnt", 128'(a_cnt), 128'(1));
        a_vld = 0;
        tick();
        check("clr_err", 128'(a_err), 128'(0));
        check("clr_cnt", 128'(a_cnt), 128'(0));
        a_clr = 0;

        // ASI back-to-back reads, ways 3..0
        a_fet[0   +: 34] = 34'h1_0000_00F0;  a_top[0   +: 34] = 34'h3_AAAA_0000;
        a_fet[34  +: 34] = 34'h2_0000_00F1;  a_top[34  +: 34] = 34'h0_AAAA_0001;
        a_fet[68  +: 34] = 34'h3_0000_00F2;  a_top[68  +: 34] = 34'h1_AAAA_0002;
        a_fet[102 +: 34] = 34'h0_0000_00F3;  a_top[102 +: 34] = 34'h2_AAAA_0003;
        exp_asi[0] = {2'b11, 2'b01, 32'hAAAA_0000, 32'h0000_00F0};
        exp_asi[1] = {2'b00, 2'b10, 32'hAAAA_0001, 32'h0000_00F1};
        exp_asi[2] = {2'b01, 2'b11, 32'hAAAA_0002, 32'h0000_00F2};
        exp_asi[3] = {2'b10, 2'b00, 32'hAAAA_0003, 32'h0000_00F3};
        a_ws = 4'b1010;
        a_req = 1;
        for (int k = 0; k < 4; k++) begin
            a_way = 2'(3 - k);
            tick();
            check("asi_vld", 128'(a_asi_vld), 128'(1));
            check("asi_data", 128'(a_asi_data), 128'(exp_asi[3 - k]));
        end
        a_req = 0;
        tick();
        check("asi_idle_vld", 128'(a_asi_vld),  128'(0));
        check("asi_idle_dat", 128'(a_asi_data), 128'(exp_asi[0]));
        check("asi_err",      128'(a_err),      128'(0));

        // Instance B: combinational select, 8 ways
        for (int k = 0; k < 8; k++) begin
            b_fet[k*18 +: 18] = 18'h00001 << k;
            b_top[k*18 +: 18] = 18'h00100 << k;
        end
        b_fet[5*18 +: 18] = 18'h2_0020;
        b_top[5*18 +: 18] = 18'h1_2000;
        b_fet[7*18 +: 18] = 18'h2_0080;
        b_vld = 1; b_ws = 8'b1000_0001;
        #1;
        check("b_fet", 128'(b_fdp_fet), 128'(18'h2_0081));
        check("b_top", 128'(b_fdp_top), 128'(18'h0_8100));
        check("b_vld", 128'(b_fdp_vld), 128'(1));
        check("b_hit", 128'(b_fdp_hit), 128'(1));
        b_ws = 8'b0000_0000;
        #1;
        check("b_miss_fet", 128'(b_fdp_fet), 128'(0));
        check("b_miss_hit", 128'(b_fdp_hit), 128'(0));
        b_vld = 0;
        #1;
        check("b_novld", 128'(b_fdp_vld), 128'(0));

        // B ASI read of way 5 (3-bit index), then reset with a request in flight
        b_req = 1; b_way = 3'd5;
        a_vld = 1; a_ws = 4'b0001;
        tick();
        check("b_asi_vld", 128'(b_asi_vld),  128'(1));
        check("b_asi_dat", 128'(b_asi_data), 128'({2'b01, 2'b10, 16'h2000, 16'h0020}));
        check("a_vld_pre", 128'(a_fdp_vld),  128'(1));
        b_vld = 1; b_ws = 8'h01;
        #2 reset = 1'b1;
        #1;
        check("mrst_b_asi",  128'(b_asi_vld),  128'(0));
        check("mrst_b_dat",  128'(b_asi_data), 128'(0));
        check("mrst_b_fet",  128'(b_fdp_fet),  128'(0));
        check("mrst_a_vld",  128'(a_fdp_vld),  128'(0));
        tick();
        reset = 1'b0;
        b_req = 0; b_vld = 0; a_vld = 0;
        tick();
        check("post_b_asi", 128'(b_asi_vld), 128'(0));
        check("post_a_vld", 128'(a_fdp_vld), 128'(0));
        check("post_a_asi", 128'(a_asi_vld), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
